// File: rtl/fetch_pkg.sv
// Shared types for the fetch unit: FSM state encoding, instruction buffer entry, default reset PC.
package fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_WAIT  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_FAULT = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } fetch_entry_t;

  function automatic logic [31:0] next_pc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Fetch unit handshake bundle: imem request/response, redirect, decoder side.
// fetch_fault exists only when FETCH_ALIGN_CHECK_EN is defined.
interface fetch_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        fetch_fault;
`endif

  modport master (
    output imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, inst_ready
`ifdef FETCH_ALIGN_CHECK_EN
    , output fetch_fault
`endif
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, inst_ready
`ifdef FETCH_ALIGN_CHECK_EN
    , input fetch_fault
`endif
  );

endinterface

// File: rtl/fetch_fifo.sv
// Instruction buffer: power-of-two ring of {pc,data}, head visible combinationally, 1-cycle push-to-valid.
// Push accepted when not full or popping the same cycle; flush empties without touching storage.
module fetch_fifo import fetch_pkg::*; #(
  parameter int  DEPTH = 2,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush_i,
  input  logic         push_i,
  input  fetch_entry_t push_dat_i,
  input  logic         pop_i,
  output logic         vld_o,
  output fetch_entry_t pop_dat_o,
  output logic [AW:0]  count_o
);

  localparam logic [AW:0]   FULL    = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   cnt_q;
  logic          do_push, do_pop;

  assign do_pop  = pop_i && (cnt_q != '0);
  assign do_push = push_i && ((cnt_q != FULL) || do_pop);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_dat_i;
        wr_ptr_q        <= wr_ptr_q + PTR_ONE;
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CNT_ONE;
        2'b01:   cnt_q <= cnt_q - CNT_ONE;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign vld_o     = (cnt_q != '0);
  assign pop_dat_o = mem_q[rd_ptr_q];
  assign count_o   = cnt_q;

endmodule

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetcher feeding a BUF_DEPTH buffer; response visible to decoder 1 cycle later.
// Requests only when a buffer slot is free, so responses are never backpressured. Option: FETCH_ALIGN_CHECK_EN.
module fetch_unit import fetch_pkg::*; #(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int          BUF_DEPTH = 2
) (
  input logic     clk,
  input logic     rst_n,
  fetch_if.master bus
);

  localparam int CW = $clog2(BUF_DEPTH) + 1;

  fetch_state_e  state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   tgt;
  logic [CW-1:0] count;
  logic          fifo_vld;
  fetch_entry_t  fifo_dat, rsp_entry;
  logic          req_fire, rsp_pend, flt_owed, push, pop;

`ifdef FETCH_ALIGN_CHECK_EN
  logic flt_pend_q;

  assign tgt      = bus.redirect_pc;
  assign flt_owed = (state_q == ST_FAULT) && flt_pend_q && !bus.imem_rsp_valid;

  // Remember whether a response was still owed when FAULT was entered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flt_pend_q <= 1'b0;
    end else if (state_q != ST_FAULT) begin
      flt_pend_q <= rsp_pend;
    end else if (bus.imem_rsp_valid) begin
      flt_pend_q <= 1'b0;
    end
  end

  assign bus.fetch_fault = (state_q == ST_FAULT);
`else
  assign tgt      = bus.redirect_pc & 32'hFFFF_FFFC;
  assign flt_owed = 1'b0;
`endif

  assign bus.imem_req_valid = rst_n && (state_q == ST_RUN) && (count < CW'(BUF_DEPTH));
  assign bus.imem_req_addr  = pc_q;
  assign req_fire           = bus.imem_req_valid && bus.imem_req_ready;

  // True when a response will still arrive after this edge.
  assign rsp_pend = req_fire || flt_owed ||
                    (((state_q == ST_WAIT) || (state_q == ST_FLUSH)) && !bus.imem_rsp_valid);

  assign push      = (state_q == ST_WAIT) && bus.imem_rsp_valid && !bus.redirect_valid;
  assign pop       = fifo_vld && bus.inst_ready && !bus.redirect_valid;
  assign rsp_entry = '{pc: pc_q, data: bus.imem_rsp_data};

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    if (bus.redirect_valid) begin
`ifdef FETCH_ALIGN_CHECK_EN
      if (bus.redirect_pc[1:0] != 2'b00) begin
        state_d = ST_FAULT;
      end else
`endif
      begin
        pc_d    = tgt;
        state_d = rsp_pend ? ST_FLUSH : ST_RUN;
      end
    end else begin
      case (state_q)
        ST_RUN:   if (req_fire) state_d = ST_WAIT;
        ST_WAIT:  if (bus.imem_rsp_valid) begin
                    state_d = ST_RUN;
                    pc_d    = next_pc(pc_q);
                  end
        ST_FLUSH: if (bus.imem_rsp_valid) state_d = ST_RUN;
        default:  state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  fetch_fifo #(.DEPTH(BUF_DEPTH)) u_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush_i    (bus.redirect_valid),
    .push_i     (push),
    .push_dat_i (rsp_entry),
    .pop_i      (pop),
    .vld_o      (fifo_vld),
    .pop_dat_o  (fifo_dat),
    .count_o    (count)
  );

  assign bus.inst_valid = fifo_vld;
  assign bus.inst_data  = fifo_dat.data;
  assign bus.inst_pc    = fifo_dat.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: per-cycle vector table plus hand sequences for wrap, alignment and reset.
// Alignment-fault sequence is selected by FETCH_ALIGN_CHECK_EN.
module tb_fetch_unit;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  fetch_if bus_if ();

  fetch_unit #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if.master)
  );

  typedef struct {
    logic        rst;
    logic        rrdy;
    logic        rvld;
    logic [31:0] rdat;
    logic        redir;
    logic [31:0] rpc;
    logic        irdy;
    logic        e_rv;
    logic [31:0] e_addr;
    logic        e_iv;
    logic [31:0] e_idat;
    logic [31:0] e_ipc;
  } vec_t;

  vec_t vt [29];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Inputs change at the falling edge; outputs are sampled 1 time unit later.
  task automatic drive(input logic r, input logic rr, input logic rv, input logic [31:0] rd,
                       input logic rdir, input logic [31:0] rp, input logic ir);
    @(negedge clk);
    rst_n                 = r;
    bus_if.imem_req_ready = rr;
    bus_if.imem_rsp_valid = rv;
    bus_if.imem_rsp_data  = rd;
    bus_if.redirect_valid = rdir;
    bus_if.redirect_pc    = rp;
    bus_if.inst_ready     = ir;
    #1;
  endtask

  initial begin
    //         rst  rrdy rvld rdat           redir rpc           irdy  e_rv e_addr         e_iv e_idat         e_ipc
    vt[0]  = '{1'b0,1'b0,1'b0,32'h0,         1'b0,32'h0,        1'b0, 1'b0,32'h0000_0000,1'b0,32'h0,         32'h0};
    vt[1]  = '{1'b1,1'b1,1'b0,32'h0,         1'b0,32'h0,        1'b1, 1'b1,32'h0000_0000,1'b0,32'h0,         32'h0};
    vt[2]  = '{1'b1,1'b1,1'b1,32'h0000_0013, 1'b0,32'h0,        1'b1, 1'b0,32'h0000_0000,1'b0,32'h0,         32'h0};
    vt[3]  = '{1'b1,1'b1,1'b0,32'h0,         1'b0,32'h0,        1'b1, 1'b1,32'h0000_0004,1'b1,32'h0000_0013, 32'h0};
    vt[4]  = '{1'b1,1'b1,1'b1,32'h0040_0093, 1'b0,32'h0,        1'b1, 1'b0,32'h0000_0004,1'b0,32'h0,         32'h0};
    vt[5]  = '{1'b1,1'b1,1'b0,32'h0,         1'b0,32'h0,        1'b1, 1'b1,32'h0000_0008,1'b1,32'h0040_0093, 32'h4};
    vt[6]  = '{1'b1,1'b1,1'b1,32'h0080_0113, 1'b0,32'h0,        1'b1, 1'b0,32'h0000_0008,1'b0,32'h0,         32'h0};
    vt[7]  = '{1'b1,1'b1,1'b0,32'h0,         1'b0,32'h0,        1'b1, 1'b1,32'h0000_000C,1'b1,32'h0080_0113, 32'h8};
    vt[8]  = '{1'b1,1'b1,1'b0,32'h0,         1'b1,32'h100,      1'b1, 1'b0,32'h0000_000C,1'b0,32'h0,         32'h0};
    vt[9]  = '{1'b1,1'b1,1'b1,32'hDEAD_BEEF, 1'b0,32'h0,        1'b1, 1'b0,32'h0000_0100,1'b0,32'h0,         32'h0};
    vt[10] = '{1'b1,1'b1,1'b0,32'h0,         1'b0,32'h0,        1'b1, 1'b1,32'h0000_0100,1'b0,32'h0,         32'h0};
    vt[11] = '{1'b1,1'b1,1'b1,32'h0000_0063, 1'b0,32'h0,        1'b1, 1'b0,32'h0000_0100,1'b0,32'h0,         32'h0};
    vt[12] = '{1'b1,1'b1,1'b0,32'h0,         1'b0,32'h0,        1'b1, 1'b1,32'h0000_0104,1'b1,32'h0000_0063, 32'h100};
    vt[13] = '{1'b1,1'b1,1'b1,32'h1111_1111, 1'b1,32'h40,       1'b1, 1'b0,32'h0000_0104,1'b0,32'h0,         32'h0};
    vt[14] = '{1'b1,1'b0,1'b0,32'h0,         1'b0,32'h0,        1'b1, 1'b1,32'h0000_0040,1'b0,32'h0,         32'h0};
    vt[15] = '{1'b1,1'b0,1'b0,32'h0,         1'b1,32'h80,       1'b1, 1'b1,32'h0000_0040,1'b0,32'h0,         32'h0};
    vt[16] = '{1'b1,1'b1,1'b0,32'h0,         1'b1,32'h300,      1'b1, 1'b1,32'h0000_0080,1'b0,32'h0,         32'h0};
    vt[17] = '{1'b1,1'b1,1'b1,32'h2222_2222, 1'b0,32'h0,        1'b1, 1'b0,32'h0000_0300,1'b0,32'h0,         32'h0};
    vt[18] = '{1'b1,1'b1,1'b0,32'h0,         1'b0,32'h0,        1'b0, 1'b1,32'h0000_0300,1'b0,32'h0,         32'h0};
    vt[19] = '{1'b1,1'b1,1'b1,32'hAAAA_0001, 1'b0,32'h0,        1'b0, 1'b0,32'h0000_0300,1'b0,32'h0,         32'h0};
    vt[20] = '{1'b1,1'b1,1'b0,32'h0,         1'b0,32'h0,        1'b0, 1'b1,32'h0000_0304,1'b1,32'hAAAA_0001, 32'h300};
    vt[21] = '{1'b1,1'b1,1'b1,32'hAAAA_0002, 1'b0,32'h0,        1'b0, 1'b0,32'h0000_0304,1'b1,32'hAAAA_0001, 32'h300};
    vt[22] = '{1'b1,1'b1,1'b0,32'h0,         1'b0,32'h0,        1'b0, 1'b0,32'h0000_0308,1'b1,32'hAAAA_0001, 32'h300};
    vt[23] = '{1'b1,1'b1,1'b0,32'h0,         1'b0,32'h0,        1'b1, 1'b0,32'h0000_0308,1'b1,32'hAAAA_0001, 32'h300};
    vt[24] = '{1'b1,1'b0,1'b0,32'h0,         1'b0,32'h0,        1'b1, 1'b1,32'h0000_0308,1'b1,32'hAAAA_0002, 32'h304};
    vt[25] = '{1'b1,1'b1,1'b0,32'h0,         1'b0,32'h0,        1'b1, 1'b1,32'h0000_0308,1'b0,32'h0,         32'h0};
    vt[26] = '{1'b1,1'b1,1'b1,32'hBBBB_0003, 1'b0,32'h0,        1'b0, 1'b0,32'h0000_0308,1'b0,32'h0,         32'h0};
    vt[27] = '{1'b1,1'b0,1'b0,32'h0,         1'b1,32'h500,      1'b1, 1'b1,32'h0000_030C,1'b1,32'hBBBB_0003, 32'h308};
    vt[28] = '{1'b1,1'b0,1'b0,32'h0,         1'b0,32'h0,        1'b1, 1'b1,32'h0000_0500,1'b0,32'h0,         32'h0};

    rst_n                 = 1'b0;
    bus_if.imem_req_ready = 1'b0;
    bus_if.imem_rsp_valid = 1'b0;
    bus_if.imem_rsp_data  = 32'h0;
    bus_if.redirect_valid = 1'b0;
    bus_if.redirect_pc    = 32'h0;
    bus_if.inst_ready     = 1'b0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 29; i++) begin
      drive(vt[i].rst, vt[i].rrdy, vt[i].rvld, vt[i].rdat, vt[i].redir, vt[i].rpc, vt[i].irdy);
      chk($sformatf("v%0d_req_valid", i), {31'b0, bus_if.imem_req_valid}, {31'b0, vt[i].e_rv});
      chk($sformatf("v%0d_req_addr", i), bus_if.imem_req_addr, vt[i].e_addr);
      chk($sformatf("v%0d_inst_valid", i), {31'b0, bus_if.inst_valid}, {31'b0, vt[i].e_iv});
      if (vt[i].e_iv || !vt[i].rst) begin
        chk($sformatf("v%0d_inst_data", i), bus_if.inst_data, vt[i].e_idat);
        chk($sformatf("v%0d_inst_pc", i), bus_if.inst_pc, vt[i].e_ipc);
      end
`ifdef FETCH_ALIGN_CHECK_EN
      chk($sformatf("v%0d_fault", i), {31'b0, bus_if.fetch_fault}, 32'h0);
`endif
    end

    // PC wrap from the last word of the address space.
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC, 1'b1);
    drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    chk("wrap_req_addr_top", bus_if.imem_req_addr, 32'hFFFF_FFFC);
    drive(1'b1, 1'b0, 1'b1, 32'h0000_006F, 1'b0, 32'h0, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    chk("wrap_req_addr_zero", bus_if.imem_req_addr, 32'h0000_0000);
    chk("wrap_req_valid", {31'b0, bus_if.imem_req_valid}, 32'h1);
    chk("wrap_inst_pc", bus_if.inst_pc, 32'hFFFF_FFFC);
    chk("wrap_inst_data", bus_if.inst_data, 32'h0000_006F);

`ifdef FETCH_ALIGN_CHECK_EN
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0102, 1'b1);
    drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    chk("fault_set", {31'b0, bus_if.fetch_fault}, 32'h1);
    chk("fault_no_req", {31'b0, bus_if.imem_req_valid}, 32'h0);
    chk("fault_buf_empty", {31'b0, bus_if.inst_valid}, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0000_0200, 1'b1);
    chk("fault_hold", {31'b0, bus_if.fetch_fault}, 32'h1);
    chk("fault_hold_no_req", {31'b0, bus_if.imem_req_valid}, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    chk("fault_clear", {31'b0, bus_if.fetch_fault}, 32'h0);
    chk("fault_clear_req", {31'b0, bus_if.imem_req_valid}, 32'h1);
    chk("fault_clear_addr", bus_if.imem_req_addr, 32'h0000_0200);
    drive(1'b1, 1'b0, 1'b1, 32'h0000_0099, 1'b0, 32'h0, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    chk("fault_after_inst_pc", bus_if.inst_pc, 32'h0000_0200);
    chk("fault_after_inst_valid", {31'b0, bus_if.inst_valid}, 32'h1);
`else
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0503, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    chk("misalign_forced_addr", bus_if.imem_req_addr, 32'h0000_0500);
    chk("misalign_req_valid", {31'b0, bus_if.imem_req_valid}, 32'h1);
`endif

    // Reset while WAIT with a buffered instruction; stale responses must vanish.
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0600, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    chk("rst_pre_addr", bus_if.imem_req_addr, 32'h0000_0600);
    drive(1'b1, 1'b0, 1'b1, 32'h0000_0077, 1'b0, 32'h0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    chk("rst_pre_inst_valid", {31'b0, bus_if.inst_valid}, 32'h1);
    chk("rst_pre_inst_pc", bus_if.inst_pc, 32'h0000_0600);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 32'h0000_0BAD, 1'b0, 32'h0, 1'b0);
    chk("rst_req_valid", {31'b0, bus_if.imem_req_valid}, 32'h0);
    chk("rst_inst_valid", {31'b0, bus_if.inst_valid}, 32'h0);
    chk("rst_inst_data", bus_if.inst_data, 32'h0);
    chk("rst_inst_pc", bus_if.inst_pc, 32'h0);
    chk("rst_req_addr", bus_if.imem_req_addr, 32'h0000_0000);
`ifdef FETCH_ALIGN_CHECK_EN
    chk("rst_fault", {31'b0, bus_if.fetch_fault}, 32'h0);
`endif
    drive(1'b1, 1'b0, 1'b1, 32'h0000_0BAD, 1'b0, 32'h0, 1'b1);
    chk("post_rst_req_valid", {31'b0, bus_if.imem_req_valid}, 32'h1);
    chk("post_rst_req_addr", bus_if.imem_req_addr, 32'h0000_0000);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    chk("post_rst_stale_dropped", {31'b0, bus_if.inst_valid}, 32'h0);
    chk("post_rst_req_addr_hold", bus_if.imem_req_addr, 32'h0000_0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
